// File: rtl/tile_match_scorer.sv
// Tile Flip game-logic stage: accepts tile flips, compares pairs, tracks
// revealed/matched tiles and keeps a saturating 4-digit packed BCD score.
module tile_match_scorer #(
  parameter int unsigned SHOW_CYCLES  = 50_000_000,
  parameter int unsigned MATCH_POINTS = 10,
  parameter int unsigned NUM_PAIRS    = 8
) (
  input  logic        clock_50Mhz,
  input  logic        reset,
  input  logic        flip_valid,
  input  logic [3:0]  flip_tile,
  input  logic [2:0]  flip_symbol,
  output logic        flip_ready,
  output logic [15:0] reveal_mask,
  output logic [15:0] matched_mask,
  output logic [15:0] score_bcd,
  output logic        match_pulse,
  output logic        miss_pulse,
  output logic        game_over
);

  localparam int unsigned HOLD_W = 26;
  localparam int unsigned CNT_W  = 4;

  // Decimal to packed BCD, evaluated at elaboration for the per-match points.
  function automatic logic [15:0] to_bcd(input int unsigned v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  localparam logic [15:0] POINTS_BCD = to_bcd(MATCH_POINTS);

  // Digit-wise BCD add; bit 16 is the carry out of the thousands digit.
  function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] r;
    logic        carry;
    logic [4:0]  d;
    r     = '0;
    carry = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = 5'(a[i*4 +: 4]) + 5'(b[i*4 +: 4]) + 5'(carry);
      if (d > 5'd9) begin
        r[i*4 +: 4] = 4'(d - 5'd10);
        carry       = 1'b1;
      end else begin
        r[i*4 +: 4] = d[3:0];
        carry       = 1'b0;
      end
    end
    r[16] = carry;
    return r;
  endfunction

  typedef enum logic [2:0] {
    WAIT_FIRST,
    WAIT_SECOND,
    COMPARE,
    HOLD,
    DONE
  } state_t;

  state_t              state, state_nxt;
  logic [3:0]          tile_a, tile_a_nxt;
  logic [3:0]          tile_b, tile_b_nxt;
  logic [2:0]          sym_a, sym_a_nxt;
  logic [2:0]          sym_b, sym_b_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt;
  logic [CNT_W-1:0]    pair_cnt, pair_cnt_nxt;
  logic [15:0]         reveal_nxt, matched_nxt, score_nxt;
  logic                match_nxt, miss_nxt, game_over_nxt;
  logic [16:0]         score_sum;

  assign score_sum = bcd_add(score_bcd, POINTS_BCD);

  // Next-state and next-register decode; flip_ready decoded from state only.
  always_comb begin
    state_nxt     = state;
    tile_a_nxt    = tile_a;
    tile_b_nxt    = tile_b;
    sym_a_nxt     = sym_a;
    sym_b_nxt     = sym_b;
    hold_cnt_nxt  = hold_cnt;
    pair_cnt_nxt  = pair_cnt;
    reveal_nxt    = reveal_mask;
    matched_nxt   = matched_mask;
    score_nxt     = score_bcd;
    match_nxt     = 1'b0;
    miss_nxt      = 1'b0;
    game_over_nxt = game_over;
    flip_ready    = 1'b0;

    case (state)
      WAIT_FIRST: begin
        flip_ready = 1'b1;
        if (flip_valid && !matched_mask[flip_tile]) begin
          tile_a_nxt            = flip_tile;
          sym_a_nxt             = flip_symbol;
          reveal_nxt[flip_tile] = 1'b1;
          state_nxt             = WAIT_SECOND;
        end
      end
      WAIT_SECOND: begin
        flip_ready = 1'b1;
        if (flip_valid && (flip_tile != tile_a) && !matched_mask[flip_tile]) begin
          tile_b_nxt            = flip_tile;
          sym_b_nxt             = flip_symbol;
          reveal_nxt[flip_tile] = 1'b1;
          state_nxt             = COMPARE;
        end
      end
      COMPARE: begin
        if (sym_a == sym_b) begin
          matched_nxt[tile_a] = 1'b1;
          matched_nxt[tile_b] = 1'b1;
          match_nxt           = 1'b1;
          score_nxt           = score_sum[16] ? 16'h9999 : score_sum[15:0];
          pair_cnt_nxt        = pair_cnt + CNT_W'(1);
          if (pair_cnt_nxt == CNT_W'(NUM_PAIRS)) begin
            game_over_nxt = 1'b1;
            state_nxt     = DONE;
          end else begin
            state_nxt = WAIT_FIRST;
          end
        end else begin
          miss_nxt     = 1'b1;
          hold_cnt_nxt = HOLD_W'(SHOW_CYCLES - 1);
          state_nxt    = HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt == '0) begin
          reveal_nxt[tile_a] = 1'b0;
          reveal_nxt[tile_b] = 1'b0;
          state_nxt          = WAIT_FIRST;
        end else begin
          hold_cnt_nxt = hold_cnt - HOLD_W'(1);
        end
      end
      DONE: begin
        flip_ready = 1'b0;
      end
      default: begin
        state_nxt = WAIT_FIRST;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock_50Mhz) begin
    if (!reset) begin
      state        <= WAIT_FIRST;
      tile_a       <= '0;
      tile_b       <= '0;
      sym_a        <= '0;
      sym_b        <= '0;
      hold_cnt     <= '0;
      pair_cnt     <= '0;
      reveal_mask  <= '0;
      matched_mask <= '0;
      score_bcd    <= '0;
      match_pulse  <= 1'b0;
      miss_pulse   <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      state        <= state_nxt;
      tile_a       <= tile_a_nxt;
      tile_b       <= tile_b_nxt;
      sym_a        <= sym_a_nxt;
      sym_b        <= sym_b_nxt;
      hold_cnt     <= hold_cnt_nxt;
      pair_cnt     <= pair_cnt_nxt;
      reveal_mask  <= reveal_nxt;
      matched_mask <= matched_nxt;
      score_bcd    <= score_nxt;
      match_pulse  <= match_nxt;
      miss_pulse   <= miss_nxt;
      game_over    <= game_over_nxt;
    end
  end

endmodule

// File: tb/tb_tile_match_scorer.sv
// Self-checking bench for tile_match_scorer: directed game, randomized game
// and a saturating-score instance with reset applied mid-hold.
module tb_tile_match_scorer;

  localparam int unsigned SHOW   = 4;
  localparam int unsigned POINTS = 10;

  logic        clock_50Mhz;
  logic        reset;
  logic        flip_valid;
  logic [3:0]  flip_tile;
  logic [2:0]  flip_symbol;
  logic        flip_ready;
  logic [15:0] reveal_mask, matched_mask, score_bcd;
  logic        match_pulse, miss_pulse, game_over;

  logic        s_reset;
  logic        s_flip_valid;
  logic [3:0]  s_flip_tile;
  logic [2:0]  s_flip_symbol;
  logic        s_flip_ready;
  logic [15:0] s_reveal_mask, s_matched_mask, s_score_bcd;
  logic        s_match_pulse, s_miss_pulse, s_game_over;

  tile_match_scorer #(.SHOW_CYCLES(SHOW), .MATCH_POINTS(POINTS), .NUM_PAIRS(8)) dut (
    .clock_50Mhz (clock_50Mhz),
    .reset       (reset),
    .flip_valid  (flip_valid),
    .flip_tile   (flip_tile),
    .flip_symbol (flip_symbol),
    .flip_ready  (flip_ready),
    .reveal_mask (reveal_mask),
    .matched_mask(matched_mask),
    .score_bcd   (score_bcd),
    .match_pulse (match_pulse),
    .miss_pulse  (miss_pulse),
    .game_over   (game_over)
  );

  tile_match_scorer #(.SHOW_CYCLES(SHOW), .MATCH_POINTS(9990), .NUM_PAIRS(8)) u_sat (
    .clock_50Mhz (clock_50Mhz),
    .reset       (s_reset),
    .flip_valid  (s_flip_valid),
    .flip_tile   (s_flip_tile),
    .flip_symbol (s_flip_symbol),
    .flip_ready  (s_flip_ready),
    .reveal_mask (s_reveal_mask),
    .matched_mask(s_matched_mask),
    .score_bcd   (s_score_bcd),
    .match_pulse (s_match_pulse),
    .miss_pulse  (s_miss_pulse),
    .game_over   (s_game_over)
  );

  initial clock_50Mhz = 1'b0;
  always #10 clock_50Mhz = ~clock_50Mhz;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: game described as sets of tiles and an integer score.
  int          sym [16];
  logic [15:0] m_matched;
  int          m_first, m_second, m_score, m_pairs;
  bit          m_done;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] exp_reveal();
    logic [15:0] r;
    r = m_matched;
    if (m_first >= 0)  r[m_first] = 1'b1;
    if (m_second >= 0) r[m_second] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_matched = '0;
    m_first   = -1;
    m_second  = -1;
    m_score   = 0;
    m_pairs   = 0;
    m_done    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock_50Mhz);
    reset       = 1'b0;
    flip_valid  = 1'b1;
    flip_tile   = 4'($urandom_range(15));
    flip_symbol = 3'($urandom_range(7));
    repeat (3) @(negedge clock_50Mhz);
    model_reset();
    chk("rst_reveal", 32'(reveal_mask), 32'(0));
    chk("rst_matched", 32'(matched_mask), 32'(0));
    chk("rst_score", 32'(score_bcd), 32'(0));
    chk("rst_ready", 32'(flip_ready), 32'(1));
    chk("rst_pulses", 32'({match_pulse, miss_pulse, game_over}), 32'(0));
    flip_valid = 1'b0;
    reset      = 1'b1;
  endtask

  // One-cycle flip request; model decides whether it is accepted.
  task automatic flip(input int t, output bit pair_done);
    pair_done = 1'b0;
    @(negedge clock_50Mhz);
    flip_valid  = 1'b1;
    flip_tile   = 4'(t);
    flip_symbol = 3'(sym[t]);
    @(negedge clock_50Mhz);
    flip_valid = 1'b0;
    if (!m_done && !m_matched[t]) begin
      if (m_first < 0) m_first = t;
      else if (t != m_first) begin
        m_second  = t;
        pair_done = 1'b1;
      end
    end
    chk("flip_reveal", 32'(reveal_mask), 32'(exp_reveal()));
    chk("flip_ready", 32'(flip_ready), 32'((pair_done || m_done) ? 0 : 1));
  endtask

  // Entered during the compare cycle that follows the second accepted flip.
  task automatic resolve();
    chk("cmp_ready", 32'(flip_ready), 32'(0));
    chk("cmp_pulses", 32'({match_pulse, miss_pulse}), 32'(0));
    @(negedge clock_50Mhz);
    if (sym[m_first] == sym[m_second]) begin
      m_matched[m_first]  = 1'b1;
      m_matched[m_second] = 1'b1;
      m_first  = -1;
      m_second = -1;
      m_pairs++;
      m_score = (m_score + POINTS > 9999) ? 9999 : m_score + POINTS;
      if (m_pairs == 8) m_done = 1'b1;
      chk("match_pulse", 32'({match_pulse, miss_pulse}), 32'(2));
      chk("match_score", 32'(score_bcd), 32'(to_bcd(m_score)));
      chk("match_matched", 32'(matched_mask), 32'(m_matched));
      chk("match_reveal", 32'(reveal_mask), 32'(exp_reveal()));
      chk("match_over", 32'(game_over), 32'(m_done));
      chk("match_ready", 32'(flip_ready), 32'(m_done ? 0 : 1));
      @(negedge clock_50Mhz);
      chk("match_pulse_end", 32'(match_pulse), 32'(0));
    end else begin
      chk("miss_pulse", 32'({match_pulse, miss_pulse}), 32'(1));
      chk("miss_score", 32'(score_bcd), 32'(to_bcd(m_score)));
      for (int k = 0; k < int'(SHOW); k++) begin
        chk("hold_reveal", 32'(reveal_mask), 32'(exp_reveal()));
        chk("hold_ready", 32'(flip_ready), 32'(0));
        if (k > 0) chk("hold_pulse", 32'(miss_pulse), 32'(0));
        flip_valid  = 1'b1;
        flip_tile   = (k == 0) ? 4'd3 : 4'($urandom_range(15));
        flip_symbol = 3'(sym[flip_tile]);
        @(negedge clock_50Mhz);
      end
      flip_valid = 1'b0;
      m_first    = -1;
      m_second   = -1;
      chk("hold_end_reveal", 32'(reveal_mask), 32'(exp_reveal()));
      chk("hold_end_ready", 32'(flip_ready), 32'(1));
      chk("hold_end_score", 32'(score_bcd), 32'(to_bcd(m_score)));
    end
  endtask

  task automatic play_pair(input int a, input int b);
    bit d;
    flip(a, d);
    flip(b, d);
    if (d) resolve();
    else chk("pair_accepted", 32'(0), 32'(1));
  endtask

  task automatic sflip(input int t, input int s);
    @(negedge clock_50Mhz);
    s_flip_valid  = 1'b1;
    s_flip_tile   = 4'(t);
    s_flip_symbol = 3'(s);
    @(negedge clock_50Mhz);
    s_flip_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit d;
    int fixed_sym [16] = '{1, 2, 5, 0, 1, 2, 0, 3, 3, 5, 4, 4, 6, 6, 7, 7};
    int un [$];
    int cand [$];
    int a, b, tmp, j, iter;

    reset         = 1'b0;
    flip_valid    = 1'b0;
    flip_tile     = '0;
    flip_symbol   = '0;
    s_reset       = 1'b0;
    s_flip_valid  = 1'b0;
    s_flip_tile   = '0;
    s_flip_symbol = '0;
    model_reset();
    foreach (fixed_sym[i]) sym[i] = fixed_sym[i];

    // Directed game with fixed layout
    do_reset();
    play_pair(2, 9);
    chk("first_match_score", 32'(score_bcd), 32'(16'h0010));
    chk("first_match_mask", 32'(matched_mask), 32'(16'h0204));
    play_pair(0, 1);
    chk("miss_score_kept", 32'(score_bcd), 32'(16'h0010));
    flip(2, d);
    flip(0, d);
    flip(0, d);
    flip(9, d);
    chk("illegal_matched", 32'(matched_mask), 32'(16'h0204));
    flip(4, d);
    if (d) resolve();
    else chk("pair_accepted", 32'(0), 32'(1));
    play_pair(3, 6);
    play_pair(1, 5);
    play_pair(7, 8);
    play_pair(10, 11);
    play_pair(12, 13);
    play_pair(14, 15);
    chk("full_score", 32'(score_bcd), 32'(16'h0080));
    chk("full_over", 32'(game_over), 32'(1));
    flip(5, d);
    repeat (2) @(negedge clock_50Mhz);
    chk("done_ready", 32'(flip_ready), 32'(0));
    chk("done_over", 32'(game_over), 32'(1));
    chk("done_reveal", 32'(reveal_mask), 32'(16'hFFFF));

    // Randomized game with shuffled layout
    for (int i = 0; i < 16; i++) sym[i] = i / 2;
    for (int i = 15; i > 0; i--) begin
      j      = int'($urandom_range(i));
      tmp    = sym[i];
      sym[i] = sym[j];
      sym[j] = tmp;
    end
    do_reset();
    iter = 0;
    while (m_pairs < 8 && iter < 60) begin
      iter++;
      un.delete();
      for (int i = 0; i < 16; i++) if (!m_matched[i]) un.push_back(i);
      a = un[$urandom_range(un.size() - 1)];
      cand.delete();
      for (int i = 0; i < 16; i++)
        if (!m_matched[i] && sym[i] != sym[a]) cand.push_back(i);
      if (cand.size() > 0 && $urandom_range(2) == 0) begin
        b = cand[$urandom_range(cand.size() - 1)];
        play_pair(a, b);
      end else begin
        b = a;
        for (int i = 0; i < 16; i++) if (i != a && sym[i] == sym[a]) b = i;
        flip(a, d);
        if ($urandom_range(1) == 1) flip(a, d);
        flip(b, d);
        if (d) resolve();
        else chk("pair_accepted", 32'(0), 32'(1));
      end
    end
    chk("rand_pairs", 32'(m_pairs), 32'(8));
    chk("rand_score", 32'(score_bcd), 32'(16'h0080));
    chk("rand_over", 32'(game_over), 32'(1));

    // Saturating score instance, then reset in the middle of a hold
    @(negedge clock_50Mhz);
    s_reset = 1'b1;
    sflip(0, 0);
    sflip(1, 0);
    @(negedge clock_50Mhz);
    chk("sat_pulse1", 32'(s_match_pulse), 32'(1));
    chk("sat_score1", 32'(s_score_bcd), 32'(to_bcd(9990)));
    chk("sat_matched1", 32'(s_matched_mask), 32'(16'h0003));
    sflip(2, 1);
    sflip(3, 1);
    @(negedge clock_50Mhz);
    chk("sat_score2", 32'(s_score_bcd), 32'(16'h9999));
    sflip(4, 2);
    sflip(5, 3);
    @(negedge clock_50Mhz);
    chk("sat_miss", 32'(s_miss_pulse), 32'(1));
    chk("sat_hold_reveal", 32'(s_reveal_mask), 32'(16'h003F));
    @(negedge clock_50Mhz);
    chk("sat_hold_ready", 32'(s_flip_ready), 32'(0));
    s_reset = 1'b0;
    @(negedge clock_50Mhz);
    chk("midhold_reveal", 32'(s_reveal_mask), 32'(0));
    chk("midhold_matched", 32'(s_matched_mask), 32'(0));
    chk("midhold_score", 32'(s_score_bcd), 32'(0));
    chk("midhold_ready", 32'(s_flip_ready), 32'(1));
    chk("midhold_flags", 32'({s_match_pulse, s_miss_pulse, s_game_over}), 32'(0));
    s_reset = 1'b1;
    repeat (SHOW + 2) @(negedge clock_50Mhz);
    chk("midhold_stays_clear", 32'(s_reveal_mask), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
